instr_loader: RTL



---
 rtl/instr_loader_pkg.sv | 23 ++
 rtl/instr_loader_byte_packer.sv | 60 ++++++
 rtl/instr_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader.
// Contents:
//   state_t        - loader FSM states
//   HDR_LEN        - number of header bytes (16-bit word count, MSB first)
//   BYTES_PER_WORD - stream bytes per instruction word (big-endian)
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Shifts stream bytes MSB-first into a 32-bit word. When the last byte of a
// word is shifted in, the completed word is registered and word_vld pulses
// for one cycle. A byte may be shifted in during the word_vld cycle; it
// starts the next word.
// Ports:
//   clk, rst_n - clock / asynchronous active-low reset
//   clr        - synchronous clear of the byte index
//   shift      - accept din this cycle
//   din        - stream byte
//   last       - the next shifted byte completes a word
//   word       - last completed word (held until the next one completes)
//   word_vld   - one-cycle strobe, word is new this cycle
// -----------------------------------------------------------------------------
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic        last,
  output logic [31:0] word,
  output logic        word_vld
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;
  // Holds the bytes of the current word received so far
  logic [23:0]      asm_q;

  assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      asm_q    <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (clr) begin
        idx <= '0;
      end else if (shift) begin
        asm_q <= {asm_q[15:0], din};
        if (last) begin
          word     <= {asm_q, din};
          word_vld <= 1'b1;
          idx      <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Receives a program as a byte stream (16-bit word count, MSB first, then
// count big-endian 32-bit words) and writes the words into instruction
// memory, holding the CPU in reset until the load completes.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// covering every stream byte, header included.
// Ports:
//   clk_i, rst_n           - clock / asynchronous active-low reset
//   byte_valid_i/data_i    - byte source; transfer when valid && ready
//   byte_ready_o           - registered; loader accepts a byte this cycle
//   reload_i               - restart pulse, honoured only in DONE or ERR
//   im_we_o/addr_o/wdata_o - instruction memory write port
//   cpu_rst_n_o            - CPU reset, released only in DONE
//   done_o, err_o          - load completed / aborted
// -----------------------------------------------------------------------------
module instr_loader
  import loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        reload_i,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH) + 1;

  state_t           state;
  logic [15:0]      count_q;
  logic [IDX_W-1:0] word_idx;
  // Final word's bytes are all in; waiting for its write cycle
  logic             last_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xor_q;
`endif

  logic        accept;
  logic        restart;
  logic        pk_last;
  logic        pk_word_vld;
  logic [15:0] count_full;

  assign accept     = byte_valid_i && byte_ready_o;
  assign restart    = reload_i && ((state == S_DONE) || (state == S_ERR));
  assign count_full = {count_q[15:8], byte_data_i};

  byte_packer u_packer (
    .clk      (clk_i),
    .rst_n    (rst_n),
    .clr      (restart),
    .shift    (accept && (state == S_DATA)),
    .din      (byte_data_i),
    .last     (pk_last),
    .word     (im_wdata_o),
    .word_vld (pk_word_vld)
  );

  // The packer's registered strobe is the write pulse; address is registered
  // alongside it below.
  assign im_we_o = pk_word_vld;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_HDR0;
      byte_ready_o <= 1'b0;
      im_addr_o    <= BASE_ADDR;
      cpu_rst_n_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      count_q      <= '0;
      word_idx     <= '0;
      last_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      if (accept && (state != S_CHK)) begin
        xor_q <= xor_q ^ byte_data_i;
      end
`endif
      case (state)
        S_HDR0: begin
          byte_ready_o <= 1'b1;
          if (accept) begin
            count_q[15:8] <= byte_data_i;
            state         <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept) begin
            count_q <= count_full;
            if (count_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state        <= S_CHK;
              byte_ready_o <= 1'b1;
`else
              state        <= S_DONE;
              byte_ready_o <= 1'b0;
              done_o       <= 1'b1;
              cpu_rst_n_o  <= 1'b1;
`endif
            end else if (32'(count_full) > 32'(DEPTH)) begin
              state        <= S_ERR;
              byte_ready_o <= 1'b0;
              err_o        <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          // Final byte of a word: latch its address for the write cycle.
          if (accept && pk_last) begin
            im_addr_o <= BASE_ADDR + (32'(word_idx) << 2);
            word_idx  <= word_idx + 1'b1;
            // Last word: stop accepting so no stray byte is consumed
            if ((32'(word_idx) + 32'd1) == 32'(count_q)) begin
              last_q       <= 1'b1;
              byte_ready_o <= 1'b0;
            end
          end
          if (pk_word_vld && last_q) begin
            last_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            state        <= S_CHK;
            byte_ready_o <= 1'b1;
`else
            state        <= S_DONE;
            byte_ready_o <= 1'b0;
            done_o       <= 1'b1;
            cpu_rst_n_o  <= 1'b1;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            byte_ready_o <= 1'b0;
            if (byte_data_i == xor_q) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              cpu_rst_n_o <= 1'b1;
            end else begin
              state <= S_ERR;
              err_o <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERR: begin
          byte_ready_o <= 1'b0;
          if (restart) begin
            state        <= S_HDR0;
            byte_ready_o <= 1'b1;
            im_addr_o    <= BASE_ADDR;
            cpu_rst_n_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            count_q      <= '0;
            word_idx     <= '0;
            last_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
          end
        end

        default: begin
          state        <= S_HDR0;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
